// File: rtl/isa_pkg.sv
// Shared types for the kernel window loader: row/window types and FSM state encoding.
package isa_pkg;

  localparam int PKG_ADDR_W = 16;
  localparam int PKG_ROW_W  = 24;

  typedef logic [PKG_ROW_W-1:0] row_t;
  typedef row_t window_t [0:2];

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    LOAD_FETCH  = 2'd1,
    LOAD_COMMIT = 2'd2,
    SLIDE_FETCH = 2'd3
  } loader_state_t;

endpackage

// File: rtl/kernel_window_loader_window_regs.sv
// Three-row window register: parallel load on commit, shift-in of a new bottom row on slide.
module window_regs #(
  parameter int ROW_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en_i,
  input  logic [ROW_W-1:0] load_rows_i [0:2],
  input  logic             shift_en_i,
  input  logic [ROW_W-1:0] shift_in_i,
  output logic [ROW_W-1:0] rows_o [0:2]
);

  logic [ROW_W-1:0] rows_q [0:2];

  // Load has priority; the FSM never asserts both in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q[0] <= '0;
      rows_q[1] <= '0;
      rows_q[2] <= '0;
    end else if (load_en_i) begin
      rows_q[0] <= load_rows_i[0];
      rows_q[1] <= load_rows_i[1];
      rows_q[2] <= load_rows_i[2];
    end else if (shift_en_i) begin
      rows_q[0] <= rows_q[1];
      rows_q[1] <= rows_q[2];
      rows_q[2] <= shift_in_i;
    end
  end

  assign rows_o = rows_q;

endmodule

// File: rtl/kernel_window_loader.sv
// Fetches and maintains the 3-row pixel window for the kernel ALU; stalls the pipeline while fetching.
// Memory handshake: a transfer completes in any cycle where mem_req && mem_ack; mem_addr is stable while mem_req waits.
module kernel_window_loader
  import isa_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int ROW_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              slide_req,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [ROW_W-1:0]  mem_rdata,
  output logic [ROW_W-1:0]  cache [0:2],
  output logic              cache_valid,
  output logic              done_o,
  output logic              stall_o,
  output loader_state_t     state_o
);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [1:0]        row_idx_q, row_idx_d;
  logic              mem_req_q, mem_req_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [ROW_W-1:0]  shadow_q [0:2];
  logic              ack;
  logic              shadow_we;
  logic              commit;
  logic              shift;

  assign ack = mem_req_q && mem_ack;

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    last_addr_d  = last_addr_q;
    row_idx_d    = row_idx_q;
    mem_req_d    = mem_req_q;
    valid_d      = valid_q;
    done_d       = 1'b0;
    shadow_we    = 1'b0;
    commit       = 1'b0;
    shift        = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_req) begin
          state_d      = LOAD_FETCH;
          row_idx_d    = 2'd0;
          fetch_addr_d = base_addr;
          valid_d      = 1'b0;
          mem_req_d    = 1'b1;
        end else if (slide_req && valid_q) begin
          state_d      = SLIDE_FETCH;
          fetch_addr_d = last_addr_q + stride;
          mem_req_d    = 1'b1;
        end
      end
      LOAD_FETCH: begin
        if (ack) begin
          shadow_we    = 1'b1;
          fetch_addr_d = fetch_addr_q + stride;
          row_idx_d    = row_idx_q + 2'd1;
          if (row_idx_q == 2'd2) begin
            state_d     = LOAD_COMMIT;
            last_addr_d = fetch_addr_q;
            mem_req_d   = 1'b0;
          end
        end
      end
      LOAD_COMMIT: begin
        commit  = 1'b1;
        valid_d = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      SLIDE_FETCH: begin
        if (ack) begin
          shift       = 1'b1;
          last_addr_d = fetch_addr_q;
          done_d      = 1'b1;
          mem_req_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      last_addr_q  <= '0;
      row_idx_q    <= 2'd0;
      mem_req_q    <= 1'b0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      shadow_q[0]  <= '0;
      shadow_q[1]  <= '0;
      shadow_q[2]  <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      last_addr_q  <= last_addr_d;
      row_idx_q    <= row_idx_d;
      mem_req_q    <= mem_req_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
      if (shadow_we) begin
        case (row_idx_q)
          2'd0:    shadow_q[0] <= mem_rdata;
          2'd1:    shadow_q[1] <= mem_rdata;
          default: shadow_q[2] <= mem_rdata;
        endcase
      end
    end
  end

  // The fetch address register doubles as the memory address, so it stays stable until acked.
  assign mem_addr    = rst ? '0 : fetch_addr_q;
  assign mem_req     = mem_req_q;
  assign cache_valid = valid_q;
  assign done_o      = done_q;
  assign stall_o     = (state_q != IDLE);
  assign state_o     = state_q;

  window_regs #(.ROW_W(ROW_W)) u_window_regs (
    .clk         (clk),
    .rst         (rst),
    .load_en_i   (commit),
    .load_rows_i (shadow_q),
    .shift_en_i  (shift),
    .shift_in_i  (mem_rdata),
    .rows_o      (cache)
  );

endmodule
